// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: ten rounds sequenced by one FSM, InvSubBytes over SBOX_LANES bytes per cycle.
// Optional key-schedule reuse between jobs is enabled by defining AES_KEY_CACHE_EN.
module aes_inv_cipher_iter #(
    parameter int SBOX_LANES = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext_in,
    input  logic [127:0] cipherkey,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext_out,
    output logic         busy,
    output logic [2:0]   o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds data stable while valid is high and ready is low.

    localparam int S = 16 / SBOX_LANES;
    localparam logic [1:0] LANE_LAST = 2'(S - 1);

    if (!(SBOX_LANES == 4 || SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
        $error("SBOX_LANES must be 4, 8 or 16");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_KEY, S_ARK0, S_ISR, S_ISB, S_ARK, S_IMC, S_DONE
    } state_t;

    state_t         r_fsm;
    state_t         w_fsm_next;
    logic [127:0]   r_data;
    logic [127:0]   r_key;
    logic [1407:0]  r_sched;
    logic [3:0]     r_rnd;
    logic [1:0]     r_lane;
    logic [1407:0]  w_sched;
    logic [3:0]     w_rk_idx;
    logic [127:0]   w_rk;
    logic [127:0]   w_isb;
    logic           w_key_hit;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [1407:0] key_expand(input logic [127:0] key);
        logic [31:0]   w [0:43];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1407:0] s;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) s[1407 - 32*i -: 32] = w[i];
        return s;
    endfunction

    // Byte index r + 4c; row r of column c moves right by r positions.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] a);
        logic [127:0] o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8*(r + 4*c) -: 8] = a[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] a);
        logic [127:0] o;
        logic [7:0]   b0, b1, b2, b3;
        for (int c = 0; c < 4; c++) begin
            b0 = a[127 - 32*c -: 8];
            b1 = a[119 - 32*c -: 8];
            b2 = a[111 - 32*c -: 8];
            b3 = a[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gf_mul(b0, 8'h0e) ^ gf_mul(b1, 8'h0b) ^ gf_mul(b2, 8'h0d) ^ gf_mul(b3, 8'h09);
            o[119 - 32*c -: 8] = gf_mul(b0, 8'h09) ^ gf_mul(b1, 8'h0e) ^ gf_mul(b2, 8'h0b) ^ gf_mul(b3, 8'h0d);
            o[111 - 32*c -: 8] = gf_mul(b0, 8'h0d) ^ gf_mul(b1, 8'h09) ^ gf_mul(b2, 8'h0e) ^ gf_mul(b3, 8'h0b);
            o[103 - 32*c -: 8] = gf_mul(b0, 8'h0b) ^ gf_mul(b1, 8'h0d) ^ gf_mul(b2, 8'h09) ^ gf_mul(b3, 8'h0e);
        end
        return o;
    endfunction

    assign w_sched  = key_expand(r_key);
    assign w_rk_idx = (r_fsm == S_ARK0) ? 4'd10 : r_rnd;

    always_comb begin
        w_rk = '0;
        for (int r = 0; r < 11; r++) begin
            if (w_rk_idx == 4'(r)) w_rk = r_sched[1407 - 128*r -: 128];
        end
    end

    always_comb begin
        w_isb = r_data;
        for (int l = 0; l < S; l++) begin
            if (r_lane == 2'(l)) begin
                for (int j = 0; j < SBOX_LANES; j++) begin
                    w_isb[127 - 8*(SBOX_LANES*l + j) -: 8] = inv_sbox(r_data[127 - 8*(SBOX_LANES*l + j) -: 8]);
                end
            end
        end
    end

`ifdef AES_KEY_CACHE_EN
    logic r_cache_valid;

    // r_sched still holds the schedule of r_key once KEY has run for it.
    assign w_key_hit = r_cache_valid && (cipherkey == r_key);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cache_valid <= 1'b0;
        end else if (r_fsm == S_KEY) begin
            r_cache_valid <= 1'b1;
        end
    end
`else
    assign w_key_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_fsm <= S_IDLE;
        else          r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next    = r_fsm;
        in_ready      = 1'b0;
        busy          = 1'b1;
        out_valid     = 1'b0;
        plaintext_out = '0;
        case (r_fsm)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_fsm_next = w_key_hit ? S_ARK0 : S_KEY;
            end
            S_KEY:  w_fsm_next = S_ARK0;
            S_ARK0: w_fsm_next = S_ISR;
            S_ISR:  w_fsm_next = S_ISB;
            S_ISB:  if (r_lane == LANE_LAST) w_fsm_next = S_ARK;
            S_ARK:  w_fsm_next = (r_rnd == 4'd0) ? S_DONE : S_IMC;
            S_IMC:  w_fsm_next = S_ISR;
            S_DONE: begin
                out_valid     = 1'b1;
                plaintext_out = r_data;
                if (out_ready) w_fsm_next = S_IDLE;
            end
            default: w_fsm_next = S_IDLE;
        endcase
    end

    assign o_dbg_state = r_fsm;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_key   <= '0;
            r_sched <= '0;
            r_rnd   <= 4'd0;
            r_lane  <= 2'd0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data <= ciphertext_in;
                        r_key  <= cipherkey;
                    end
                end
                S_KEY:  r_sched <= w_sched;
                S_ARK0: begin
                    r_data <= r_data ^ w_rk;
                    r_rnd  <= 4'd9;
                end
                S_ISR: begin
                    r_data <= inv_shift_rows(r_data);
                    r_lane <= 2'd0;
                end
                S_ISB: begin
                    r_data <= w_isb;
                    if (r_lane != LANE_LAST) r_lane <= r_lane + 2'd1;
                end
                S_ARK:  r_data <= r_data ^ w_rk;
                S_IMC: begin
                    r_data <= inv_mix_columns(r_data);
                    r_rnd  <= r_rnd - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: two instances (16 and 4 S-box lanes) decrypt the same jobs;
// expected plaintexts come from a forward AES-128 encryption model of the chosen plaintexts.
module tb_aes_inv_cipher_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam int BUDGET = 200;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic [127:0] ct_in;
    logic [127:0] key_in;
    logic         out_ready_a, out_ready_b;
    logic         in_ready_a, in_ready_b;
    logic         out_valid_a, out_valid_b;
    logic         busy_a, busy_b;
    logic [127:0] pt_a, pt_b;
    logic [2:0]   dbg_a, dbg_b;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [127:0] exp_q[$];
    bit           cache_valid;
    logic [127:0] cache_key;

    always #5 clk = ~clk;

    aes_inv_cipher_iter #(.SBOX_LANES(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .ciphertext_in(ct_in), .cipherkey(key_in), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .plaintext_out(pt_a), .busy(busy_a), .o_dbg_state(dbg_a)
    );

    aes_inv_cipher_iter #(.SBOX_LANES(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .ciphertext_in(ct_in), .cipherkey(key_in), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .plaintext_out(pt_b), .busy(busy_b), .o_dbg_state(dbg_b)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward AES-128 on a byte array, bytes indexed row + 4*column.
    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [7:0]   w [44][4];
        logic [7:0]   t [4];
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int k = 0; k < 16; k++) st[k] = pt[127 - 8*k -: 8];
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = key[127 - 8*(4*i + j) -: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % 4 == 0) begin
                t[0] = SBOX[w[i-1][1]] ^ rc;
                t[1] = SBOX[w[i-1][2]];
                t[2] = SBOX[w[i-1][3]];
                t[3] = SBOX[w[i-1][0]];
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
        end
        for (int k = 0; k < 16; k++) st[k] = st[k] ^ w[k/4][k%4];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) st[k] = SBOX[st[k]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++) tmp[row + 4*col] = st[row + 4*((col + row) % 4)];
            for (int k = 0; k < 16; k++) st[k] = tmp[k];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int k = 0; k < 16; k++) st[k] = st[k] ^ w[4*r + k/4][k%4];
        end
        for (int k = 0; k < 16; k++) res[127 - 8*k -: 8] = st[k];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " in_ready_a"}, 128'(in_ready_a), 128'd1);
        check({tag, " out_valid_a"}, 128'(out_valid_a), 128'd0);
        check({tag, " busy_a"}, 128'(busy_a), 128'd0);
        check({tag, " plaintext_a"}, pt_a, 128'd0);
        check({tag, " in_ready_b"}, 128'(in_ready_b), 128'd1);
        check({tag, " out_valid_b"}, 128'(out_valid_b), 128'd0);
        check({tag, " busy_b"}, 128'(busy_b), 128'd0);
        check({tag, " plaintext_b"}, pt_b, 128'd0);
    endtask

    // One job on both instances; the 16-lane result waits under backpressure until the 4-lane one is done.
    task automatic run_job(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] exp_pt,
                           input bit pulse_busy);
        int           cyc, lat_a, lat_b, hit;
        bit           da, db;
        logic [127:0] hold_a, hold_b, exp;
        hit = 0;
`ifdef AES_KEY_CACHE_EN
        hit = (cache_valid && key == cache_key) ? 1 : 0;
`endif
        cache_valid = 1'b1;
        cache_key   = key;
        exp_q.push_back(exp_pt);
        @(negedge clk);
        check("ready before accept a", 128'(in_ready_a), 128'd1);
        check("ready before accept b", 128'(in_ready_b), 128'd1);
        in_valid = 1'b1;
        ct_in    = ct;
        key_in   = key;
        cyc = 0; da = 1'b0; db = 1'b0; lat_a = -1; lat_b = -1; hold_a = '0; hold_b = '0;
        while (!(da && db) && cyc < BUDGET) begin
            @(negedge clk);
            if (cyc == 0) in_valid = 1'b0;
            if (pulse_busy && cyc == 10) begin
                in_valid = 1'b1;
                ct_in    = rand128();
                key_in   = rand128();
            end
            if (pulse_busy && cyc == 11) in_valid = 1'b0;
            if (!da) begin
                if (out_valid_a) begin
                    da = 1'b1; lat_a = cyc; hold_a = pt_a;
                end else begin
                    check("busy_a while running", 128'(busy_a), 128'd1);
                    check("in_ready_a while running", 128'(in_ready_a), 128'd0);
                end
            end else begin
                check("out_valid_a held", 128'(out_valid_a), 128'd1);
                check("plaintext_a stable", pt_a, hold_a);
            end
            if (!db) begin
                if (out_valid_b) begin
                    db = 1'b1; lat_b = cyc; hold_b = pt_b;
                end else begin
                    check("busy_b while running", 128'(busy_b), 128'd1);
                    check("in_ready_b while running", 128'(in_ready_b), 128'd0);
                end
            end
            cyc++;
        end
        in_valid = 1'b0;
        check("finished within budget", 128'(da && db), 128'd1);
        exp = exp_q.pop_front();
        check("latency_a", 128'(lat_a), 128'(41 - hit));
        check("latency_b", 128'(lat_b), 128'(71 - hit));
        check("plaintext_a", hold_a, exp);
        check("plaintext_b", hold_b, exp);
        check("plaintext_b now", pt_b, exp);
        out_ready_a = 1'b1;
        out_ready_b = 1'b1;
        @(negedge clk);
        out_ready_a = 1'b0;
        out_ready_b = 1'b0;
        check_idle("after out_ready");
    endtask

    initial begin
        logic [127:0] pt, key;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        ct_in       = '0;
        key_in      = '0;
        out_ready_a = 1'b0;
        out_ready_b = 1'b0;
        cache_valid = 1'b0;
        cache_key   = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        reset_n = 1'b1;

        run_job(C1_CT, C1_KEY, C1_PT, 1'b0);
        run_job(C1_CT, C1_KEY, C1_PT, 1'b1);

        for (int i = 0; i < 5; i++) begin
            pt  = rand128();
            key = ($urandom_range(0, 1) == 1) ? cache_key : rand128();
            run_job(aes_encrypt(pt, key), key, pt, (i == 2));
        end

        // Abort a job mid-round, then confirm a clean restart.
        @(negedge clk);
        in_valid = 1'b1;
        ct_in    = rand128();
        key_in   = C1_KEY;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_idle("async reset mid-run");
        @(negedge clk);
        reset_n     = 1'b1;
        cache_valid = 1'b0;
        run_job(C1_CT, C1_KEY, C1_PT, 1'b0);
        run_job(C1_CT, C1_KEY, C1_PT, 1'b0);

        pt  = rand128();
        key = rand128();
        run_job(aes_encrypt(pt, key), key, pt, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
